fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares one write port of the team's 8-entry, 4-bit synchronous FIFO among NUM_REQ producers using round-robin arbitration.
- Tracks FIFO free space with a credit counter. A write is never issued into a full FIFO, because the FIFO clears all its contents if it is written while full.
- Sits between the producer blocks and the FIFO write side. It monitors the consumer's read strobe to return credits.

Parameters:
- DATA_W, 4, data word width; must match the FIFO.
- ADDR_W, 3, FIFO address width.
- DEPTH, 1<<ADDR_W, FIFO capacity in words; sets the initial credit.
- NUM_REQ, 4, number of producers, 2..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-producer write request; held until granted.
- req_data  in  NUM_REQ*DATA_W  producer data; slice i is bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; registered.
- fifo_wr_en  out  1  to the FIFO write enable; registered.
- fifo_data_in  out  DATA_W  to the FIFO data input; registered.
- fifo_rd_en  in  1  monitored copy of the consumer's FIFO read enable.
- fifo_empty  in  1  from the FIFO.
- fifo_full  in  1  from the FIFO.
- credit  out  ADDR_W+1  current free-slot count, range 0..DEPTH.
- err  out  1  sticky consistency error.

Behaviour:
- Reset values: gnt=0, fifo_wr_en=0, fifo_data_in=0, credit=DEPTH, err=0, rr_ptr=NUM_REQ-1.
  - A reset during a pending grant drops that grant; no write is issued.
- Eligibility at each edge: eligible = req & ~gnt. A requester whose gnt is high in the current cycle is excluded, because its req is stale.
- Grant decision at each edge:
  - Condition: credit_eff > 0 and eligible != 0.
  - Winner: the first eligible index searching rr_ptr+1, rr_ptr+2, ..., with wrap modulo NUM_REQ.
  - Registered results after the edge: gnt[winner]=1, fifo_wr_en=1, fifo_data_in=req_data[winner], rr_ptr=winner.
  - Otherwise: gnt=0, fifo_wr_en=0, and fifo_data_in holds its value.
- Latency: req sampled at edge E produces gnt/wr_en in cycle E..E+1. The FIFO captures the word at edge E+1.
  - The producer may change its data or drop req at E+1.
  - If req stays high, the next grant to that producer is no earlier than E+2.
- Read return: rd_ret = fifo_rd_en & ~fifo_empty, sampled at the edge. Reads of an empty FIFO return no credit.
- credit_eff = credit + rd_ret. A credit returned at an edge is usable for a grant at that same edge.
- Credit update: credit_next = credit + rd_ret - grant_now.
  - Simultaneous grant and return leaves credit unchanged.
  - Width ADDR_W+1; credit never exceeds DEPTH and never wraps below 0.
- At credit=0 with no return: no grant; requesters stall and hold req/data.
- Error: err is set and stays set until rst in either case:
  - fifo_full=1 while credit>0 and fifo_wr_en=0; or
  - rd_ret=1 while credit=DEPTH.
- Throughput: one write per cycle when at least two requesters are active and credit is available.

Optional Feature:
- FIFO_ARB_PRIO0_EN
- Defined: requester 0 has fixed highest priority. If eligible[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated; the other requesters rotate round-robin among themselves.
- Undefined: pure round-robin over all requesters.

Decomposition:
- Package fifo_arb_pkg: DATA_W, ADDR_W, DEPTH, NUM_REQ defaults, and the credit width constant.
- Sub-module rr_pick: a combinational round-robin picker with inputs eligible and rr_ptr, outputs winner index and valid.
- All sequencing, the credit counter, and err stay in fifo_wr_arbiter.

Test Plan:
- Reset then idle: credit=8, gnt=0, fifo_wr_en=0, err=0; rst asserted mid-grant clears gnt and wr_en immediately.
- req=4'b1111 held, data i=4'hA+i, no reads: grants go 0,1,2,3,0,1,2,3 on consecutive cycles; credit reaches 0 after 8 writes; gnt then stays 0; fifo_full=1, err=0.
- Single requester req=4'b0100 held: gnt[2] every other cycle, wr_en duty 50%.
- credit=0, fifo_rd_en=1, fifo_empty=0 in the same cycle as req=4'b0001: grant issued at that edge, credit stays 0.
- fifo_rd_en=1 with fifo_empty=1 at credit=8: credit stays 8, err=0. Force fifo_full=1 at credit=3 with no write: err=1 and sticky.
- FIFO_ARB_PRIO0_EN defined, req=4'b1011 held: gnt[0] every other cycle, with gnt[1] and gnt[3] alternating in the gaps.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared constants for the FIFO write-port arbiter: default data/address
//   widths, FIFO depth, number of producers, credit counter width, and a
//   helper that sizes requester index signals.
//   No ports (package).
package fifo_arb_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int ADDR_W_DEF   = 3;
  localparam int DEPTH_DEF    = 1 << ADDR_W_DEF;
  localparam int NUM_REQ_DEF  = 4;
  localparam int CREDIT_W_DEF = ADDR_W_DEF + 1;

  // Width of a requester index; at least one bit even for two producers.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches eligible[] starting at
//   rr_ptr+1 and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   eligible  in   NUM_REQ  candidate requesters
//   rr_ptr    in   IDX_W    index of the previous winner
//   winner    out  IDX_W    chosen index (0 when valid=0)
//   valid     out  1        at least one requester eligible
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible index
  // after rr_ptr is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (eligible[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of an 8-entry synchronous FIFO among
//   NUM_REQ producers with round-robin arbitration. A credit counter tracks
//   free FIFO slots so a write is never issued into a full FIFO (the FIFO
//   clears itself when written while full). Consumer reads of a non-empty
//   FIFO return credit.
//   Build option: define FIFO_ARB_PRIO0_EN to give requester 0 fixed top
//   priority; the remaining requesters rotate among themselves.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             per-producer write request, held until granted
//   req_data        producer data, slice i = [i*DATA_W +: DATA_W]
//   gnt             one-hot one-cycle grant pulse (registered)
//   fifo_wr_en      FIFO write enable (registered)
//   fifo_data_in    FIFO write data (registered)
//   fifo_rd_en      monitored consumer read enable
//   fifo_empty      FIFO empty flag
//   fifo_full       FIFO full flag
//   credit          free-slot count, 0..DEPTH
//   err             sticky consistency error
//
// Handshake: a producer raises req with valid data and holds both until it
// sees its gnt bit high for one cycle. The arbiter samples req/req_data at
// the edge that sets gnt; the FIFO captures fifo_data_in at the following
// edge, at which point the producer may change data or drop req.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 1 << ADDR_W,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_rd_en,
  input  logic                      fifo_empty,
  input  logic                      fifo_full,
  output logic [ADDR_W:0]           credit,
  output logic                      err
);

  localparam int CW    = ADDR_W + 1;
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               rd_ret;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rr_elig;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   winner;
  logic               have_winner;
  logic               update_ptr;
  logic               credit_avail;
  logic               grant_now;
  logic [CW:0]        credit_sum;

  // A requester granted this cycle still shows its old req; exclude it.
  assign eligible = req & ~gnt_q;

`ifdef FIFO_ARB_PRIO0_EN
  // Requester 0 is handled by fixed priority, so the rotation skips it.
  assign rr_elig = {eligible[NUM_REQ-1:1], 1'b0};
`else
  assign rr_elig = eligible;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible (rr_elig),
    .rr_ptr   (rr_ptr_q),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    rd_ret       = fifo_rd_en & ~fifo_empty;
    winner       = pick_idx;
    have_winner  = pick_valid;
    update_ptr   = 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
    if (eligible[0]) begin
      winner      = '0;
      have_winner = 1'b1;
      update_ptr  = 1'b0;
    end
`endif
    // A credit returned at this edge may be spent at this same edge.
    credit_avail = (credit_q != '0) | rd_ret;
    grant_now    = have_winner & credit_avail;

    gnt_d    = '0;
    wr_en_d  = grant_now;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_now) begin
      gnt_d  = NUM_REQ'(1) << winner;
      data_d = req_data[int'(winner)*DATA_W +: DATA_W];
      if (update_ptr) begin
        rr_ptr_d = winner;
      end
    end

    // One extra bit absorbs the transient credit+1 before saturation; a
    // return at full credit is an error and must not push credit past DEPTH.
    credit_sum = {1'b0, credit_q} + (CW+1)'(rd_ret) - (CW+1)'(grant_now);
    if (credit_sum > (CW+1)'(DEPTH)) begin
      credit_d = CW'(DEPTH);
    end else begin
      credit_d = credit_sum[CW-1:0];
    end

    // FIFO claims full while we believe slots are free (and no write is in
    // flight), or a read returns credit we never spent.
    err_d = err_q
          | (fifo_full & (credit_q != '0) & ~wr_en_q)
          | (rd_ret & (credit_q == CW'(DEPTH)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= '0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      credit_q <= CW'(DEPTH);
      err_q    <= 1'b0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      gnt_q    <= gnt_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign credit       = credit_q;
  assign err          = err_q;

endmodule
